regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 3, giving the number of write-back requesters.
REQ-002 The block SHALL have parameter NREGS, default 8, giving the number of architectural registers.
REQ-003 The block SHALL have parameter ADDR_W, default 6, giving the register address width.
REQ-004 The block SHALL have parameter DATA_W, default 32, giving the data width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have port req_valid, input, NREQ bits: per-requester write request.
REQ-008 The block SHALL have port req_addr, input, NREQ*ADDR_W bits: per-requester target register, packed with requester 0 in the LSBs.
REQ-009 The block SHALL have port req_data, input, NREQ*DATA_W bits: per-requester write data, packed the same way.
REQ-010 The block SHALL have port req_ready, output, NREQ bits: per-requester accept.
REQ-011 The block SHALL have port write_enabled, output, 1 bit: register-file write strobe.
REQ-012 The block SHALL have port write_addr, output, ADDR_W bits: register-file write address.
REQ-013 The block SHALL have port write_data, output, DATA_W bits: register-file write data.
REQ-014 The block SHALL have port rsv_valid, input, 1 bit: issue stage reserves a destination register.
REQ-015 The block SHALL have port rsv_addr, input, ADDR_W bits: register being reserved.
REQ-016 The block SHALL have port busy, output, NREGS bits: scoreboard with one bit per register, 1 meaning a write is pending.
REQ-017 The block SHALL have port addr_err, output, 1 bit: sticky flag for an out-of-range address.

Function
REQ-018 Arbitration SHALL be round-robin among asserted req_valid bits, with at most one grant per cycle.
REQ-019 req_ready[i] SHALL be a combinational function of req_valid and the priority pointer, and SHALL be high only for the granted requester.
REQ-020 A transfer SHALL occur when req_valid[i] and req_ready[i] are both high at posedge.
REQ-021 A requester SHALL hold its valid, addr and data stable until its transfer occurs.
REQ-022 After a grant to requester i, the priority pointer SHALL move to (i+1) mod NREQ; with no grant, the pointer SHALL hold.
REQ-023 A transfer accepted at edge N SHALL drive write_enabled=1 and the registered addr and data during cycle N+1 (latency 1).
REQ-024 With no transfer, write_enabled SHALL be 0 in the following cycle, and write_addr/write_data SHALL hold their last values.
REQ-025 The output stage SHALL never stall, so the arbiter sustains 1 write per cycle.
REQ-026 A transfer with addr >= NREGS SHALL be accepted, SHALL set addr_err, and SHALL NOT assert write_enabled.
REQ-027 addr_err SHALL clear only on reset.
REQ-028 An rsv_valid with rsv_addr < NREGS SHALL set busy[rsv_addr] at posedge.
REQ-029 An rsv_valid with rsv_addr >= NREGS SHALL set addr_err and change no busy bit.
REQ-030 busy[a] SHALL clear on the edge ending the cycle in which write_enabled=1 with write_addr=a.
REQ-031 When a set and a clear hit the same register on the same edge, the set SHALL win.
REQ-032 Register 0 SHALL be treated like any other register, with no hard-wired zero.

Reset
REQ-033 While reset=0 at posedge, the block SHALL force write_enabled=0, write_addr=0, write_data=0, busy=0, addr_err=0 and the priority pointer to requester 0.
REQ-034 req_ready SHALL be all-zero during any cycle with reset=0.
REQ-035 A transfer or reservation presented in a reset cycle SHALL be discarded.
REQ-036 A write pending in the output stage when reset asserts SHALL be dropped.

Configuration
REQ-037 The macro REGFILE_WB_ARB_SCOREBOARD_EN SHALL control the scoreboard.
REQ-038 With REGFILE_WB_ARB_SCOREBOARD_EN defined, the busy/rsv logic SHALL be as in REQ-028..031.
REQ-039 With REGFILE_WB_ARB_SCOREBOARD_EN undefined, busy SHALL be tied to 0, rsv_valid/rsv_addr SHALL be ignored, and no scoreboard flops SHALL exist.
REQ-040 The port list SHALL be identical with and without REGFILE_WB_ARB_SCOREBOARD_EN.

Structure
REQ-041 Package regfile_pkg SHALL hold the NREGS/ADDR_W/DATA_W defaults and the typedefs reg_addr_t and reg_data_t, shared with the register file.
REQ-042 Sub-module rr_arbiter SHALL be parameterised by NREQ, take valid and a pointer, and return a one-hot grant.
REQ-043 The top level SHALL contain the pointer, output register and scoreboard.

Verification
REQ-044 Single request: after reset, req_valid=001, addr=3, data=0xDEADBEEF -> req_ready=001 the same cycle; next cycle write_enabled=1, write_addr=3, write_data=0xDEADBEEF.
REQ-045 Contention: req_valid=111 held for 6 cycles -> grants in order 0,1,2,0,1,2; write_enabled high for 6 consecutive cycles.
REQ-046 Scoreboard: rsv to reg 5, then requester 1 writes reg 5 -> busy[5]=1 until the edge after the write_enabled cycle, then 0; rsv and write to reg 5 on the same edge -> busy[5] stays 1.
REQ-047 Bad address: requester 2 writes addr=9 -> req_ready=1, no write_enabled, addr_err=1 and sticky until reset.
REQ-048 Reset mid-operation: reset=0 while a write is pending and busy=0x24 -> next cycle write_enabled=0, busy=0, pointer at 0 (req_valid=110 grants 1 first).
REQ-049 Macro off: repeat the REQ-046 stimulus -> busy stays 0x00 throughout.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file package: default geometry and the address/data
// typedefs used by the write-back arbiter and the register file itself.
package regfile_pkg;

   localparam int NREGS_DEF  = 8;
   localparam int ADDR_W_DEF = 6;
   localparam int DATA_W_DEF = 32;

   typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
   typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage : regfile_pkg

// File: rtl/rr_arbiter.sv
// Round-robin grant selection. Purely combinational: the requester at or
// after i_ptr (wrapping) with a valid bit set wins; grant is one-hot or zero.
module rr_arbiter #(
   parameter int NREQ  = 3,
   parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0]  i_valid,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [NREQ-1:0]  o_grant
);

   logic w_found;

   // Walk requesters in priority order starting at the pointer; first valid wins.
   always_comb begin
      o_grant = '0;
      w_found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!w_found && i_valid[i] &&
                (((32'(i_ptr) + 32'(k)) % 32'(NREQ)) == 32'(i))) begin
               o_grant[i] = 1'b1;
               w_found    = 1'b1;
            end
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file: round-robin selection among
// NREQ requesters, a one-cycle registered write port, a sticky address
// error flag and (with REGFILE_WB_ARB_SCOREBOARD_EN defined) a per-register
// pending-write scoreboard. Without the macro, busy is tied low.
//
// Handshake: req_valid[i] is held with stable addr/data until accepted;
// req_ready[i] is a combinational grant and a transfer happens on any
// posedge where req_valid[i] && req_ready[i]. The write port never stalls.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int NREQ   = 3,
   parameter int NREGS  = NREGS_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ*DATA_W-1:0]   req_data,
   output logic [NREQ-1:0]          req_ready,
   output logic                     write_enabled,
   output logic [ADDR_W-1:0]        write_addr,
   output logic [DATA_W-1:0]        write_data,
   input  logic                     rsv_valid,
   input  logic [ADDR_W-1:0]        rsv_addr,
   output logic [NREGS-1:0]         busy,
   output logic                     addr_err
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PTR_W-1:0]  r_ptr;
   logic              r_we;
   logic [ADDR_W-1:0] r_waddr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_err;

   logic [NREQ-1:0]   w_grant;
   logic              w_xfer;
   logic [PTR_W-1:0]  w_gnt_idx;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_data;
   logic              w_sel_ok;
   logic              w_rsv_err;

   rr_arbiter #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_rr_arbiter (
      .i_valid (req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_grant)
   );

   // Grants are suppressed while reset is low so nothing is accepted then.
   assign req_ready = reset ? w_grant : '0;
   assign w_xfer    = |req_ready;

   // Mux the granted requester's index, address and data.
   always_comb begin
      w_gnt_idx  = '0;
      w_sel_addr = '0;
      w_sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_grant[i]) begin
            w_gnt_idx  = PTR_W'(i);
            w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            w_sel_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign w_sel_ok = (32'(w_sel_addr) < 32'(NREGS));

   // Priority pointer, write-port register and sticky address error.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_ptr   <= '0;
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_err   <= 1'b0;
      end else begin
         // Out-of-range writes are accepted but never reach the register file.
         r_we <= w_xfer && w_sel_ok;
         if (w_xfer) begin
            r_ptr <= (w_gnt_idx == PTR_W'(NREQ-1)) ? '0 : w_gnt_idx + PTR_W'(1);
            if (w_sel_ok) begin
               r_waddr <= w_sel_addr;
               r_wdata <= w_sel_data;
            end
         end
         if ((w_xfer && !w_sel_ok) || w_rsv_err) begin
            r_err <= 1'b1;
         end
      end
   end

   assign write_enabled = r_we;
   assign write_addr    = r_waddr;
   assign write_data    = r_wdata;
   assign addr_err      = r_err;

`ifdef REGFILE_WB_ARB_SCOREBOARD_EN
   logic [NREGS-1:0] r_busy;
   logic             w_rsv_ok;

   assign w_rsv_ok  = (32'(rsv_addr) < 32'(NREGS));
   assign w_rsv_err = rsv_valid && !w_rsv_ok;

   // Scoreboard: reservation sets, completed write clears; set wins a tie.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_busy <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (rsv_valid && w_rsv_ok && (32'(rsv_addr) == 32'(i))) begin
               r_busy[i] <= 1'b1;
            end else if (r_we && (32'(r_waddr) == 32'(i))) begin
               r_busy[i] <= 1'b0;
            end
         end
      end
   end

   assign busy = r_busy;
`else
   logic w_unused_rsv;

   assign w_unused_rsv = ^{rsv_valid, rsv_addr};
   assign w_rsv_err    = 1'b0;
   assign busy         = '0;
`endif

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// behavioural model of arbitration, write port, error flag and scoreboard.
module tb_regfile_wb_arbiter;

   localparam int NREQ   = 3;
   localparam int NREGS  = 8;
   localparam int ADDR_W = 6;
   localparam int DATA_W = 32;
`ifdef REGFILE_WB_ARB_SCOREBOARD_EN
   localparam bit SB_EN = 1'b1;
`else
   localparam bit SB_EN = 1'b0;
`endif

   logic                   clk;
   logic                   reset;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ*DATA_W-1:0] req_data;
   logic [NREQ-1:0]        req_ready;
   logic                   write_enabled;
   logic [ADDR_W-1:0]      write_addr;
   logic [DATA_W-1:0]      write_data;
   logic                   rsv_valid;
   logic [ADDR_W-1:0]      rsv_addr;
   logic [NREGS-1:0]       busy;
   logic                   addr_err;

   regfile_wb_arbiter #(
      .NREQ   (NREQ),
      .NREGS  (NREGS),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_addr      (req_addr),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .write_enabled (write_enabled),
      .write_addr    (write_addr),
      .write_data    (write_data),
      .rsv_valid     (rsv_valid),
      .rsv_addr      (rsv_addr),
      .busy          (busy),
      .addr_err      (addr_err)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- counters / check ----------------
   int n_vec = 0;
   int n_err = 0;
   bit chk_on = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int                m_ptr = 0;
   bit                m_we = 1'b0;
   logic [ADDR_W-1:0] m_addr = '0;
   logic [DATA_W-1:0] m_data = '0;
   logic [NREGS-1:0]  m_busy = '0;
   bit                m_err = 1'b0;
   int                m_last_gnt = -1;
   int                mg;
   logic [ADDR_W-1:0] ma;

   // Winner is the valid requester closest to the pointer going upward, wrapping.
   function automatic int exp_grant(input logic [NREQ-1:0] v, input int p);
      int best   = -1;
      int best_d = NREQ;
      for (int i = 0; i < NREQ; i++) begin
         if (v[i]) begin
            int d = (i - p + NREQ) % NREQ;
            if (d < best_d) begin
               best_d = d;
               best   = i;
            end
         end
      end
      return best;
   endfunction

   always @(posedge clk) begin
      if (!reset) begin
         m_ptr = 0; m_we = 1'b0; m_addr = '0; m_data = '0;
         m_busy = '0; m_err = 1'b0; m_last_gnt = -1;
      end else begin
         mg = exp_grant(req_valid, m_ptr);
         if (SB_EN && m_we) m_busy[m_addr] = 1'b0;
         if (SB_EN && rsv_valid) begin
            if (rsv_addr < NREGS) m_busy[rsv_addr] = 1'b1;
            else m_err = 1'b1;
         end
         if (mg >= 0) begin
            m_ptr = (mg + 1) % NREQ;
            ma = req_addr[mg*ADDR_W +: ADDR_W];
            if (ma < NREGS) begin
               m_we = 1'b1; m_addr = ma; m_data = req_data[mg*DATA_W +: DATA_W];
            end else begin
               m_we = 1'b0; m_err = 1'b1;
            end
         end else begin
            m_we = 1'b0;
         end
         m_last_gnt = mg;
      end
   end

   // ---------------- per-cycle compare ----------------
   int              cg;
   logic [NREQ-1:0] er;

   always @(negedge clk) begin
      if (chk_on) begin
         cg = reset ? exp_grant(req_valid, m_ptr) : -1;
         er = '0;
         if (cg >= 0) er[cg] = 1'b1;
         check("ready",    64'(req_ready),     64'(er));
         check("we",       64'(write_enabled), 64'(m_we));
         check("waddr",    64'(write_addr),    64'(m_addr));
         check("wdata",    64'(write_data),    64'(m_data));
         check("busy",     64'(busy),          64'(m_busy));
         check("addr_err", 64'(addr_err),      64'(m_err));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic do_reset();
      step();
      reset = 1'b0;
      step();
      reset = 1'b1;
   endtask

   task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      req_addr[i*ADDR_W +: ADDR_W] = a;
      req_data[i*DATA_W +: DATA_W] = d;
   endtask

   function automatic logic [ADDR_W-1:0] rand_addr();
      if ($urandom_range(0, 99) < 92) return ADDR_W'($urandom_range(0, NREGS-1));
      return ADDR_W'($urandom_range(NREGS, (1 << ADDR_W) - 1));
   endfunction

   logic [NREGS-1:0] sb20;
   logic [NREGS-1:0] sb24;

   // ---------------- stimulus ----------------
   initial begin
      sb20 = SB_EN ? NREGS'(8'h20) : '0;
      sb24 = SB_EN ? NREGS'(8'h24) : '0;

      // Reset with activity on every input; all of it must be discarded.
      reset = 1'b0; req_valid = '1; req_addr = '0; req_data = '0;
      rsv_valid = 1'b1; rsv_addr = 6'd5;
      step();
      chk_on = 1'b1;
      step();
      at_neg();
      check("rst_ready", 64'(req_ready),     64'(0));
      check("rst_we",    64'(write_enabled), 64'(0));
      check("rst_addr",  64'(write_addr),    64'(0));
      check("rst_data",  64'(write_data),    64'(0));
      check("rst_busy",  64'(busy),          64'(0));
      check("rst_err",   64'(addr_err),      64'(0));
      step();
      reset = 1'b1; req_valid = '0; rsv_valid = 1'b0;
      at_neg();
      check("discard_we", 64'(write_enabled), 64'(0));

      // Single request.
      step();
      req_valid = 3'b001; set_req(0, 6'd3, 32'hDEADBEEF);
      at_neg();
      check("single_ready", 64'(req_ready), 64'(3'b001));
      step();
      req_valid = '0;
      at_neg();
      check("single_we",   64'(write_enabled), 64'(1));
      check("single_addr", 64'(write_addr),    64'(3));
      check("single_data", 64'(write_data),    64'(32'hDEADBEEF));

      // Contention: all three requesting for six cycles.
      do_reset();
      set_req(0, 6'd1, 32'h1111_0000);
      set_req(1, 6'd2, 32'h2222_0000);
      set_req(2, 6'd4, 32'h4444_0000);
      req_valid = 3'b111;
      for (int k = 0; k < 6; k++) begin
         at_neg();
         check("rr_order", 64'(req_ready), 64'(1) << (k % 3));
         if (k > 0) check("rr_we", 64'(write_enabled), 64'(1));
         step();
      end
      req_valid = '0;
      at_neg();
      check("rr_we_last", 64'(write_enabled), 64'(1));
      step();
      at_neg();
      check("rr_we_idle", 64'(write_enabled), 64'(0));

      // Bad address from requester 2.
      step();
      req_valid = 3'b100; set_req(2, 6'd9, 32'hBAD0_0009);
      at_neg();
      check("bad_ready", 64'(req_ready), 64'(3'b100));
      step();
      req_valid = '0;
      at_neg();
      check("bad_we",  64'(write_enabled), 64'(0));
      check("bad_err", 64'(addr_err),      64'(1));
      repeat (3) step();
      at_neg();
      check("bad_err_sticky", 64'(addr_err), 64'(1));

      // Scoreboard: reserve then write reg 5.
      do_reset();
      at_neg();
      check("err_cleared", 64'(addr_err), 64'(0));
      step();
      rsv_valid = 1'b1; rsv_addr = 6'd5;
      step();
      rsv_valid = 1'b0; req_valid = 3'b010; set_req(1, 6'd5, 32'h5555_AAAA);
      at_neg();
      check("sb_set",   64'(busy),      64'(sb20));
      check("sb_ready", 64'(req_ready), 64'(3'b010));
      step();
      req_valid = '0;
      at_neg();
      check("sb_we",   64'(write_enabled), 64'(1));
      check("sb_hold", 64'(busy),          64'(sb20));
      step();
      at_neg();
      check("sb_clear", 64'(busy), 64'(0));

      // Reserve and write-complete of reg 5 on the same edge.
      step();
      rsv_valid = 1'b1; rsv_addr = 6'd5;
      step();
      rsv_valid = 1'b0; req_valid = 3'b010;
      step();
      req_valid = '0; rsv_valid = 1'b1; rsv_addr = 6'd5;
      at_neg();
      check("tie_we", 64'(write_enabled), 64'(1));
      step();
      rsv_valid = 1'b0;
      at_neg();
      check("tie_busy", 64'(busy), 64'(sb20));

      // Reset while a write sits in the output stage and busy is 0x24.
      step();
      rsv_valid = 1'b1; rsv_addr = 6'd2; req_valid = 3'b001; set_req(0, 6'd7, 32'h7777_7777);
      step();
      rsv_valid = 1'b0; req_valid = '0; reset = 1'b0;
      at_neg();
      check("mid_we_pend", 64'(write_enabled), 64'(1));
      check("mid_busy",    64'(busy),          64'(sb24));
      step();
      at_neg();
      check("mid_we_drop", 64'(write_enabled), 64'(0));
      check("mid_busy0",   64'(busy),          64'(0));
      step();
      reset = 1'b1; req_valid = 3'b110; set_req(1, 6'd1, 32'hA1); set_req(2, 6'd6, 32'hA2);
      at_neg();
      check("mid_first", 64'(req_ready), 64'(3'b010));
      step();
      req_valid = 3'b100;
      at_neg();
      check("mid_second", 64'(req_ready), 64'(3'b100));
      step();
      req_valid = '0;

      // Randomized traffic; requesters hold until their transfer.
      for (int n = 0; n < 600; n++) begin
         step();
         reset = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && m_last_gnt == i) begin
               req_valid[i] = 1'($urandom_range(0, 1));
               if (req_valid[i]) set_req(i, rand_addr(), $urandom);
            end else if (!req_valid[i] && $urandom_range(0, 99) < 40) begin
               req_valid[i] = 1'b1;
               set_req(i, rand_addr(), $urandom);
            end
         end
         rsv_valid = ($urandom_range(0, 99) < 30);
         rsv_addr  = rand_addr();
      end
      step();
      at_neg();
      chk_on = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_regfile_wb_arbiter
